state_ctrl_reg: RTL and testbench
=================================

STATE_CTRL_REG -- requirements
Module: state_ctrl_reg

Interface
REQ-001 Parameter STATE_W, default 3: width of the state encoding.
REQ-002 Parameter NUM_STATES, default 5: legal states 0..NUM_STATES-1 (IF, ID, EXE, MEM, WB); NUM_STATES SHALL be at most 2**STATE_W.
REQ-003 Parameter FETCH_STATE, default 0: instruction-boundary state, reset and recovery target.
REQ-004 Parameter MAX_CYC, default 8: watchdog limit on edges per instruction outside FETCH_STATE; MAX_CYC SHALL be at least 2.
REQ-005 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-006 CLK  in  1  single clock; one clock; all state updates on the falling edge of CLK.
REQ-007 RST  in  1  reset, synchronous and active-high.
REQ-008 next_state  in  STATE_W  next state from control logic (ALU/decoder).
REQ-009 stall  in  1  hold the current state.
REQ-010 flush  in  1  abandon the current instruction and return to FETCH_STATE.
REQ-011 err_clr  in  1  clear the sticky error flags.
REQ-012 out  out  STATE_W  current state.
REQ-013 prev_state  out  STATE_W  state held before the last accepted update.
REQ-014 cyc_cnt  out  clog2(MAX_CYC)+1  non-stalled edges since the last entry to FETCH_STATE.
REQ-015 retire  out  1  one-cycle pulse, instruction completed.
REQ-016 instr_cnt  out  CNT_W  retired-instruction count, wraps modulo 2**CNT_W.
REQ-017 err_illegal, err_timeout  out  1 each  sticky error flags.

Function
REQ-018 Each falling edge SHALL evaluate, in strict priority: RST, flush, stall, illegal, timeout, normal.
REQ-019 Flush: out=FETCH_STATE, prev_state=old out, cyc_cnt=0, retire=0, instr_cnt unchanged.
REQ-020 Stall (flush=0): out, prev_state, cyc_cnt and instr_cnt hold; retire=0.
REQ-021 Illegal (next_state>=NUM_STATES): out=FETCH_STATE, prev_state=old out, cyc_cnt=0, err_illegal=1, retire=0.
REQ-022 Timeout (next_state!=FETCH_STATE and cyc_cnt==MAX_CYC-1): out=FETCH_STATE, prev_state=old out, cyc_cnt=0, err_timeout=1, retire=0.
REQ-023 Normal: out=next_state, prev_state=old out.
REQ-023a Normal, next_state==FETCH_STATE: cyc_cnt=0; retire=1 only if old out!=FETCH_STATE, otherwise retire=0.
REQ-023b Normal, next_state!=FETCH_STATE: cyc_cnt increments by 1; retire=0.
REQ-024 instr_cnt SHALL increment on the same edge that sets retire=1; from all-ones it SHALL wrap to 0.
REQ-025 FETCH_STATE->FETCH_STATE self-loops SHALL NOT retire and SHALL keep cyc_cnt at 0.
REQ-026 err_clr=1 SHALL clear both error flags; a new error on the same edge wins (flag reads 1).
REQ-027 Error flags SHALL NOT be cleared by flush or stall.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 RST=1 at a falling edge SHALL force out=prev_state=FETCH_STATE, cyc_cnt=0, retire=0, instr_cnt=0, err_illegal=0, err_timeout=0, overriding all other inputs.
REQ-030 RST asserted mid-instruction SHALL discard that instruction without a retire pulse.
REQ-031 Outputs SHALL also power up at the reset values for simulation.

Structure
REQ-032 State encodings (IF=0, ID=1, EXE=2, MEM=3, WB=4) and the default STATE_W SHALL live in the shared CPU control package, with FETCH_STATE defaulting to IF.
REQ-033 The wrapping retired-instruction counter SHALL be one sub-module, wrap_counter (width parameter, synchronous clear, enable).

Verification
REQ-034 RST=1 for 2 edges with next_state=3 -> out=0, instr_cnt=0, both error flags=0.
REQ-035 next_state sequence 1,2,3,4,0 -> out follows on each falling edge; cyc_cnt 1,2,3,4,0; retire=1 on the 5th edge only; instr_cnt=1.
REQ-036 At out=2: stall=1 for 3 edges with next_state=3 -> out=2, cyc_cnt=2, prev_state held; on release, out=3.
REQ-037 next_state=6 from out=1 -> out=0, err_illegal=1, no retire; err_clr=1 at the next edge -> err_illegal=0.
REQ-038 next_state held at 1 from out=1 for 8 edges -> timeout edge: out=0, err_timeout=1; flush and stall asserted together -> flush wins, out=0.
REQ-039 CNT_W=2 with 5 completed instructions -> instr_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/state_ctrl_reg_pkg.sv
// Shared CPU control definitions: pipeline state encodings and default widths
// for the instruction-sequencing state register.
package state_ctrl_reg_pkg;

  localparam int STATE_W_DEF    = 3;
  localparam int NUM_STATES_DEF = 5;

  typedef enum logic [STATE_W_DEF-1:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } cpu_state_e;

  function automatic int cyc_width(input int max_cyc);
    return $clog2(max_cyc) + 1;
  endfunction

endpackage

// File: rtl/state_ctrl_reg_wrap_counter.sv
// Free-running wrap-around event counter with synchronous clear, clocked on
// the falling edge so it shares the state register's update edge.
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q = '0;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(negedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/state_ctrl_reg.sv
// CPU control state register: tracks the pipeline state, the previous state,
// a per-instruction watchdog and a retired-instruction count.
module state_ctrl_reg
  import state_ctrl_reg_pkg::*;
#(
  parameter int STATE_W     = STATE_W_DEF,
  parameter int NUM_STATES  = NUM_STATES_DEF,
  parameter int FETCH_STATE = int'(ST_IF),
  parameter int MAX_CYC     = 8,
  parameter int CNT_W       = 16,
  localparam int CYC_W      = cyc_width(MAX_CYC)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [STATE_W-1:0] next_state,
  input  logic               stall,
  input  logic               flush,
  input  logic               err_clr,
  output logic [STATE_W-1:0] out,
  output logic [STATE_W-1:0] prev_state,
  output logic [CYC_W-1:0]   cyc_cnt,
  output logic               retire,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic               err_illegal,
  output logic               err_timeout
);

  localparam logic [STATE_W-1:0] FETCH_ST = STATE_W'(FETCH_STATE);
  localparam logic [CYC_W-1:0]   CYC_LAST = CYC_W'(MAX_CYC - 1);

  // Initialisers give reset-equivalent power-up values in simulation.
  logic [STATE_W-1:0] out_q         = FETCH_ST;
  logic [STATE_W-1:0] prev_q        = FETCH_ST;
  logic [CYC_W-1:0]   cyc_q         = '0;
  logic               retire_q      = 1'b0;
  logic               err_illegal_q = 1'b0;
  logic               err_timeout_q = 1'b0;

  logic [STATE_W-1:0] out_d, prev_d;
  logic [CYC_W-1:0]   cyc_d;
  logic               retire_d, err_illegal_d, err_timeout_d;
  logic               is_illegal, is_timeout;

  assign is_illegal = 32'(next_state) >= NUM_STATES;
  assign is_timeout = (next_state != FETCH_ST) && (cyc_q == CYC_LAST);

  always_comb begin
    out_d         = out_q;
    prev_d        = prev_q;
    cyc_d         = cyc_q;
    retire_d      = 1'b0;
    err_illegal_d = err_illegal_q & ~err_clr;
    err_timeout_d = err_timeout_q & ~err_clr;

    if (flush) begin
      out_d  = FETCH_ST;
      prev_d = out_q;
      cyc_d  = '0;
    end else if (!stall) begin
      prev_d = out_q;
      if (is_illegal) begin
        out_d         = FETCH_ST;
        cyc_d         = '0;
        err_illegal_d = 1'b1;
      end else if (is_timeout) begin
        out_d         = FETCH_ST;
        cyc_d         = '0;
        err_timeout_d = 1'b1;
      end else begin
        out_d = next_state;
        if (next_state == FETCH_ST) begin
          // A fetch self-loop is idle time, not a completed instruction.
          cyc_d    = '0;
          retire_d = (out_q != FETCH_ST);
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
    end
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      out_q         <= FETCH_ST;
      prev_q        <= FETCH_ST;
      cyc_q         <= '0;
      retire_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      out_q         <= out_d;
      prev_q        <= prev_d;
      cyc_q         <= cyc_d;
      retire_q      <= retire_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  wrap_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (CLK),
    .clr (RST),
    .en  (retire_d),
    .cnt (instr_cnt)
  );

  assign out         = out_q;
  assign prev_state  = prev_q;
  assign cyc_cnt     = cyc_q;
  assign retire      = retire_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_state_ctrl_reg.sv
// Bench for state_ctrl_reg: directed scenarios plus randomized traffic against
// a rule-level reference model; a second instance checks a narrow counter.
module tb_state_ctrl_reg;

  localparam int NUM = 5;
  localparam int MAXC = 8;

  logic       CLK = 1'b1;
  logic       RST = 1'b0;
  logic [2:0] next_state = '0;
  logic       stall = 1'b0, flush = 1'b0, err_clr = 1'b0;

  logic [2:0]  out, prev_state, out2, prev2;
  logic [3:0]  cyc_cnt, cyc2;
  logic        retire, retire2, err_illegal, err_timeout, ill2, to2;
  logic [15:0] instr_cnt;
  logic [1:0]  instr_cnt2;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_out, m_prev, m_cyc, m_cnt;
  bit m_ret, m_ill, m_to;

  always #5 CLK = ~CLK;

  state_ctrl_reg dut (
    .CLK(CLK), .RST(RST), .next_state(next_state), .stall(stall), .flush(flush),
    .err_clr(err_clr), .out(out), .prev_state(prev_state), .cyc_cnt(cyc_cnt),
    .retire(retire), .instr_cnt(instr_cnt), .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  state_ctrl_reg #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .next_state(next_state), .stall(stall), .flush(flush),
    .err_clr(err_clr), .out(out2), .prev_state(prev2), .cyc_cnt(cyc2),
    .retire(retire2), .instr_cnt(instr_cnt2), .err_illegal(ill2),
    .err_timeout(to2)
  );

  task automatic model_edge(input bit rst, input bit fl, input bit st,
                            input bit clr, input int nxt);
    bit set_ill = 0, set_to = 0;
    if (rst) begin
      m_out = 0; m_prev = 0; m_cyc = 0; m_cnt = 0;
      m_ret = 0; m_ill = 0; m_to = 0;
      return;
    end
    m_ret = 0;
    if (fl) begin
      m_prev = m_out; m_out = 0; m_cyc = 0;
    end else if (!st) begin
      m_prev = m_out;
      if (nxt >= NUM) begin
        m_out = 0; m_cyc = 0; set_ill = 1;
      end else if (nxt != 0 && m_cyc == MAXC - 1) begin
        m_out = 0; m_cyc = 0; set_to = 1;
      end else begin
        if (nxt == 0) begin
          m_ret = (m_out != 0);
          m_cyc = 0;
        end else begin
          m_cyc = m_cyc + 1;
        end
        m_out = nxt;
        if (m_ret) m_cnt = m_cnt + 1;
      end
    end
    m_ill = set_ill || (m_ill && !clr);
    m_to  = set_to  || (m_to && !clr);
  endtask

  // Drive one set of inputs, let one falling edge pass, then advance the model.
  task automatic tick(input bit rst, input bit fl, input bit st, input bit clr,
                      input int nxt);
    RST = rst; flush = fl; stall = st; err_clr = clr; next_state = 3'(nxt);
    @(negedge CLK);
    #1;
    model_edge(rst, fl, st, clr, nxt);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 3);
    tick(1, 0, 0, 0, 3);
    checks++;
    if (out !== 3'd0 || prev_state !== 3'd0 || cyc_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: out=%0d prev=%0d cyc=%0d, want 0 0 0", out, prev_state, cyc_cnt);
    end
    checks++;
    if (instr_cnt !== 16'd0 || err_illegal !== 1'b0 || err_timeout !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: instr=%0d ill=%0b to=%0b ret=%0b, want 0 0 0 0",
               instr_cnt, err_illegal, err_timeout, retire);
    end
  endtask

  task automatic test_sequence();
    int seq[5] = '{1, 2, 3, 4, 0};
    int cyc_exp[5] = '{1, 2, 3, 4, 0};
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, seq[i]);
      checks++;
      if (out !== 3'(seq[i]) || cyc_cnt !== 4'(cyc_exp[i]) || retire !== (i == 4)) begin
        errors++;
        $display("FAIL seq_step%0d: out=%0d cyc=%0d ret=%0b, want %0d %0d %0b",
                 i, out, cyc_cnt, retire, seq[i], cyc_exp[i], (i == 4));
      end
    end
    checks++;
    if (instr_cnt !== 16'd1 || prev_state !== 3'd4) begin
      errors++;
      $display("FAIL seq_count: instr=%0d prev=%0d, want 1 4", instr_cnt, prev_state);
    end
  endtask

  task automatic test_stall();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 3);
      checks++;
      if (out !== 3'd2 || cyc_cnt !== 4'd2 || prev_state !== 3'd1 || retire !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: out=%0d cyc=%0d prev=%0d, want 2 2 1", i, out, cyc_cnt, prev_state);
      end
    end
    tick(0, 0, 0, 0, 3);
    checks++;
    if (out !== 3'd3 || prev_state !== 3'd2 || cyc_cnt !== 4'd3) begin
      errors++;
      $display("FAIL stall_release: out=%0d prev=%0d cyc=%0d, want 3 2 3", out, prev_state, cyc_cnt);
    end
  endtask

  task automatic test_illegal();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 6);
    checks++;
    if (out !== 3'd0 || err_illegal !== 1'b1 || retire !== 1'b0 || prev_state !== 3'd1 || instr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL illegal_hit: out=%0d ill=%0b ret=%0b prev=%0d instr=%0d, want 0 1 0 1 0",
               out, err_illegal, retire, prev_state, instr_cnt);
    end
    tick(0, 0, 0, 1, 0);
    checks++;
    if (err_illegal !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: ill=%0b ret=%0b, want 0 0", err_illegal, retire);
    end
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 7);
    checks++;
    if (err_illegal !== 1'b1 || out !== 3'd0) begin
      errors++;
      $display("FAIL clr_vs_new_err: ill=%0b out=%0d, want 1 0", err_illegal, out);
    end
  endtask

  task automatic test_timeout();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0, 1);
      if (i < 7) begin
        checks++;
        if (out !== 3'd1 || cyc_cnt !== 4'(i + 1) || err_timeout !== 1'b0) begin
          errors++;
          $display("FAIL tmo_run%0d: out=%0d cyc=%0d to=%0b, want 1 %0d 0", i, out, cyc_cnt, err_timeout, i + 1);
        end
      end else begin
        checks++;
        if (out !== 3'd0 || cyc_cnt !== 4'd0 || err_timeout !== 1'b1 || retire !== 1'b0) begin
          errors++;
          $display("FAIL tmo_edge: out=%0d cyc=%0d to=%0b ret=%0b, want 0 0 1 0", out, cyc_cnt, err_timeout, retire);
        end
      end
    end
    tick(0, 0, 0, 0, 2);
    tick(0, 1, 1, 0, 3);
    checks++;
    if (out !== 3'd0 || prev_state !== 3'd2 || cyc_cnt !== 4'd0 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL flush_over_stall: out=%0d prev=%0d cyc=%0d to=%0b, want 0 2 0 1",
               out, prev_state, cyc_cnt, err_timeout);
    end
  endtask

  task automatic test_wrap();
    int exp2[5] = '{1, 2, 3, 0, 1};
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 2);
      tick(0, 0, 0, 0, 0);
      checks++;
      if (instr_cnt2 !== 2'(exp2[i]) || instr_cnt !== 16'(i + 1) || retire2 !== 1'b1) begin
        errors++;
        $display("FAIL wrap_instr%0d: narrow=%0d wide=%0d ret=%0b, want %0d %0d 1",
                 i, instr_cnt2, instr_cnt, retire2, exp2[i], i + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [30:0] got, want;
    int nxt;
    bit rst, fl, st, clr;
    tick(1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(63) == 0);
      fl  = ($urandom_range(15) == 0);
      st  = ($urandom_range(7) == 0);
      clr = ($urandom_range(7) == 0);
      case ($urandom_range(9))
        0:       nxt = $urandom_range(7);
        1, 2, 3: nxt = 0;
        default: nxt = $urandom_range(4, 1);
      endcase
      RST = rst; flush = fl; stall = st; err_clr = clr; next_state = 3'(nxt);
      #2;
      checks++;
      if (out !== 3'(m_out) || retire !== m_ret) begin
        errors++;
        $display("FAIL rand_comb_path%0d: out=%0d ret=%0b, want %0d %0b", n, out, retire, m_out, m_ret);
      end
      @(negedge CLK);
      #1;
      model_edge(rst, fl, st, clr, nxt);
      got  = {out, prev_state, cyc_cnt, retire, instr_cnt, err_illegal, err_timeout, instr_cnt2};
      want = {3'(m_out), 3'(m_prev), 4'(m_cyc), m_ret, 16'(m_cnt), m_ill, m_to, 2'(m_cnt)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rand_edge%0d: got=%h want=%h (next=%0d rst=%0b fl=%0b st=%0b clr=%0b)",
                 n, got, want, nxt, rst, fl, st, clr);
      end
    end
  endtask

  initial begin
    #2;
    checks++;
    if (out !== 3'd0 || instr_cnt !== 16'd0 || err_illegal !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL power_up: out=%0d instr=%0d ill=%0b to=%0b, want 0 0 0 0",
               out, instr_cnt, err_illegal, err_timeout);
    end
    test_reset();
    test_sequence();
    test_stall();
    test_illegal();
    test_timeout();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
